// File: rtl/dotp_sched.sv
// Sequencer for the two-lane multiply-add pipeline: accepts N operand beats,
// tracks in-flight beats with a latency-matched tag shift and sums tagged outputs.
`default_nettype none

module dotp_sched #(
  parameter int LEN_W    = 5,
  parameter int PIPE_LAT = 2
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [LEN_W-1:0] len,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [31:0]      in_a1,
  input  logic [31:0]      in_b1,
  input  logic [31:0]      in_a2,
  input  logic [31:0]      in_b2,
  output logic [31:0]      pipe_a1,
  output logic [31:0]      pipe_b1,
  output logic [31:0]      pipe_a2,
  output logic [31:0]      pipe_b2,
  input  logic [31:0]      pipe_c,
  output logic             busy,
  output logic             done,
  output logic [31:0]      result
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    FEED  = 2'd1,
    DRAIN = 2'd2
  } state_e;

  // Every tag bit except the one leaving the shift register this cycle.
  localparam logic [PIPE_LAT-1:0] LOW_MASK = {PIPE_LAT{1'b1}} >> 1;

  // Handshake: a beat transfers on a rising edge where in_valid && in_ready;
  // in_ready depends only on state, never on in_valid.
  state_e             state_q, state_d;
  logic [LEN_W-1:0]   len_q, len_d;
  logic [LEN_W-1:0]   cnt_q, cnt_d;
  logic [LEN_W-1:0]   cnt_inc;
  logic [PIPE_LAT-1:0] tag_q, tag_d;
  logic [31:0]        acc_q, acc_d;
  logic [31:0]        result_q, result_d;
  logic               done_q, done_d;
  logic               accept;
  logic               tag_out;
  logic               last_in_flight;

  assign in_ready       = (state_q == FEED);
  assign accept         = in_valid && in_ready;
  assign tag_out        = tag_q[PIPE_LAT-1];
  assign last_in_flight = tag_out && ((tag_q & LOW_MASK) == '0);
  assign cnt_inc        = cnt_q + 1'b1;

  // Idle lanes are driven to zero; their outputs carry no tag and are never summed.
  assign pipe_a1 = accept ? in_a1 : '0;
  assign pipe_b1 = accept ? in_b1 : '0;
  assign pipe_a2 = accept ? in_a2 : '0;
  assign pipe_b2 = accept ? in_b2 : '0;

  assign busy   = (state_q != IDLE);
  assign done   = done_q;
  assign result = result_q;

  always_comb begin
    state_d  = state_q;
    len_d    = len_q;
    cnt_d    = cnt_q;
    acc_d    = acc_q;
    result_d = result_q;
    done_d   = 1'b0;
    tag_d    = tag_q << 1;
    tag_d[0] = accept;

    if (tag_out) begin
      acc_d = acc_q + pipe_c;
    end

    case (state_q)
      IDLE: begin
        if (start) begin
          if (len != '0) begin
            len_d   = len;
            acc_d   = '0;
            cnt_d   = '0;
            state_d = FEED;
          end else begin
            result_d = '0;
            done_d   = 1'b1;
          end
        end
      end
      FEED: begin
        if (accept) begin
          cnt_d = cnt_inc;
          if (cnt_inc == len_q) begin
            state_d = DRAIN;
          end
        end
      end
      DRAIN: begin
        // No new tags enter here, so the lone tag at the output is the final beat.
        if (last_in_flight) begin
          result_d = acc_q + pipe_c;
          done_d   = 1'b1;
          state_d  = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q  <= IDLE;
      len_q    <= '0;
      cnt_q    <= '0;
      tag_q    <= '0;
      acc_q    <= '0;
      result_q <= '0;
      done_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      len_q    <= len_d;
      cnt_q    <= cnt_d;
      tag_q    <= tag_d;
      acc_q    <= acc_d;
      result_q <= result_d;
      done_q   <= done_d;
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_dotp_sched.sv
// Directed bench for dotp_sched with a behavioural two-stage multiply-add pipeline beside it.
module tb_dotp_sched;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        start;
  logic [4:0]  len;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] in_a1, in_b1, in_a2, in_b2;
  logic [31:0] pipe_a1, pipe_b1, pipe_a2, pipe_b2;
  logic [31:0] pipe_c;
  logic [31:0] pipe_s1;
  logic        busy;
  logic        done;
  logic [31:0] result;

  int cyc    = 0;
  int checks = 0;
  int passed = 0;
  int t0;

  always #5 clk = ~clk;

  // Pipeline: inputs sampled at edge e, C valid after edge e+1, no reset.
  always @(posedge clk) begin
    pipe_s1 <= pipe_a1 * pipe_b1 + pipe_a2 * pipe_b2;
    pipe_c  <= pipe_s1;
  end

  dotp_sched #(.LEN_W(5), .PIPE_LAT(2)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .start    (start),
    .len      (len),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .in_a1    (in_a1),
    .in_b1    (in_b1),
    .in_a2    (in_a2),
    .in_b2    (in_b2),
    .pipe_a1  (pipe_a1),
    .pipe_b1  (pipe_b1),
    .pipe_a2  (pipe_a2),
    .pipe_b2  (pipe_b2),
    .pipe_c   (pipe_c),
    .busy     (busy),
    .done     (done),
    .result   (result)
  );

  task automatic tick();
    @(posedge clk);
    #1;
    cyc++;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) passed++;
    else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
  endtask

  task automatic clear_ops();
    in_valid = 1'b0;
    in_a1 = '0; in_b1 = '0; in_a2 = '0; in_b2 = '0;
  endtask

  task automatic do_start(input logic [4:0] l);
    start = 1'b1;
    len   = l;
    tick();
    start = 1'b0;
    t0    = cyc;
  endtask

  task automatic send_beat(input string tag, input logic [31:0] a1, b1, a2, b2);
    in_valid = 1'b1;
    in_a1 = a1; in_b1 = b1; in_a2 = a2; in_b2 = b2;
    #1;
    chk({tag, "_ready"}, 32'(in_ready), 32'd1);
    chk({tag, "_pipe_a1"}, pipe_a1, a1);
    tick();
    clear_ops();
  endtask

  task automatic bubble(input string tag);
    in_valid = 1'b0;
    in_a1 = 32'hDEAD_BEEF; in_b1 = 32'h1234_5678;
    #1;
    chk({tag, "_pipe_a1_zero"}, pipe_a1, 32'd0);
    tick();
    clear_ops();
  endtask

  // Bounded wait for done; a timeout shows up as a wrong completion edge.
  task automatic wait_done(input string tag, input int exp_edges, input logic [31:0] exp_res);
    int n = 0;
    while (done !== 1'b1 && n < 16) begin
      tick();
      n++;
    end
    chk({tag, "_done_edge"}, 32'(cyc - t0), 32'(exp_edges));
    chk({tag, "_result"}, result, exp_res);
    chk({tag, "_busy_in_done"}, 32'(busy), 32'd0);
  endtask

  initial begin
    rst_n = 1'b0;
    start = 1'b0;
    len   = '0;
    clear_ops();
    tick();
    tick();
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_done", 32'(done), 32'd0);
    chk("rst_result", result, 32'd0);
    chk("rst_ready", 32'(in_ready), 32'd0);
    rst_n = 1'b1;
    tick();

    // len=1 single beat: 2*3 + 4*5 = 26; upstream keeps valid high while draining.
    do_start(5'd1);
    chk("l1_busy", 32'(busy), 32'd1);
    send_beat("l1_b1", 32'd2, 32'd3, 32'd4, 32'd5);
    in_valid = 1'b1; in_a1 = 32'd99; in_b1 = 32'd99;
    #1;
    chk("l1_drain_ready", 32'(in_ready), 32'd0);
    chk("l1_drain_pipe_zero", pipe_a1, 32'd0);
    chk("l1_drain_done", 32'(done), 32'd0);
    wait_done("l1", 3, 32'd26);
    clear_ops();
    tick();
    chk("l1_done_pulse", 32'(done), 32'd0);
    chk("l1_result_hold", result, 32'd26);

    // len=4 contiguous, with a stray start during FEED: 2+6+12+20 = 40.
    do_start(5'd4);
    send_beat("l4_b1", 32'd1, 32'd1, 32'd1, 32'd1);
    send_beat("l4_b2", 32'd2, 32'd2, 32'd1, 32'd2);
    start = 1'b1; len = 5'd2;
    send_beat("l4_b3", 32'd3, 32'd3, 32'd1, 32'd3);
    start = 1'b0;
    send_beat("l4_b4", 32'd4, 32'd4, 32'd1, 32'd4);
    chk("l4_ready_low", 32'(in_ready), 32'd0);
    chk("l4_busy", 32'(busy), 32'd1);
    wait_done("l4", 6, 32'd40);
    tick();
    chk("l4_idle", 32'(busy), 32'd0);

    // Bubbles: valid 1,0,1,0,1 -> completion at edge 7, result 2+8+18 = 28.
    do_start(5'd3);
    send_beat("bub_b1", 32'd1, 32'd1, 32'd1, 32'd1);
    bubble("bub_g1");
    send_beat("bub_b2", 32'd2, 32'd2, 32'd2, 32'd2);
    bubble("bub_g2");
    send_beat("bub_b3", 32'd3, 32'd3, 32'd3, 32'd3);
    wait_done("bub", 7, 32'd28);

    // Wrap-around to zero, then start in the done cycle for a truncated-product beat.
    tick();
    do_start(5'd1);
    send_beat("wrap_b1", 32'hFFFF_FFFF, 32'd1, 32'd1, 32'd1);
    wait_done("wrap", 3, 32'd0);
    do_start(5'd1);
    chk("b2b_busy", 32'(busy), 32'd1);
    send_beat("trunc_b1", 32'h0001_0000, 32'h0001_0000, 32'd3, 32'd3);
    wait_done("trunc", 3, 32'd9);
    tick();

    // len=0: immediate done with zero result, never busy.
    do_start(5'd0);
    chk("l0_done", 32'(done), 32'd1);
    chk("l0_result", result, 32'd0);
    chk("l0_busy", 32'(busy), 32'd0);
    tick();
    chk("l0_pulse", 32'(done), 32'd0);

    // Reset after 2 of 4 beats, then a clean len=1 op: 6*7 + 1*1 = 43.
    do_start(5'd4);
    send_beat("rst_b1", 32'd5, 32'd5, 32'd5, 32'd5);
    send_beat("rst_b2", 32'd5, 32'd5, 32'd5, 32'd5);
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    chk("midrst_busy", 32'(busy), 32'd0);
    chk("midrst_done", 32'(done), 32'd0);
    chk("midrst_result", result, 32'd0);
    do_start(5'd1);
    send_beat("post_b1", 32'd6, 32'd7, 32'd1, 32'd1);
    wait_done("post", 3, 32'd43);
    tick();
    chk("post_pulse", 32'(done), 32'd0);

    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
